// File: rtl/crc_stream_pkg.sv
// Shared definitions for the streaming CRC encoder: mode constants, FSM states
// and a single-bit MSB-first CRC step usable for any width up to 32.
package crc_stream_pkg;

  localparam int unsigned MODE_WORD  = 0;
  localparam int unsigned MODE_FRAME = 1;
  localparam int unsigned CRC_MAX_W  = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACC     = 2'd1,
    ST_PAR_OUT = 2'd2
  } crc_state_e;

  // One LFSR step on a right-aligned register of width crc_w inside a 32-bit container.
  function automatic logic [CRC_MAX_W-1:0] crc_fold_bit(
    input logic [CRC_MAX_W-1:0] crc,
    input logic                 b,
    input logic [CRC_MAX_W-1:0] poly,
    input int unsigned          crc_w
  );
    logic [CRC_MAX_W-1:0] mask;
    logic [CRC_MAX_W-1:0] nxt;
    logic                 fb;
    mask = (crc_w >= CRC_MAX_W) ? '1 : ((32'd1 << crc_w) - 32'd1);
    fb   = (((crc >> (crc_w - 1)) & 32'd1) != 32'd0) ^ b;
    nxt  = (crc << 1) ^ (fb ? poly : '0);
    return nxt & mask;
  endfunction

endpackage

// File: rtl/crc_stream_enc_fold.sv
// Purely combinational fold of one full data beat into a CRC register,
// data bit 0 (leftmost) processed first.
module crc_fold_comb
  import crc_stream_pkg::*;
#(
  parameter int unsigned      DATA_W = 32,
  parameter int unsigned      CRC_W  = 7,
  parameter logic [CRC_W-1:0] POLY   = 7'h09
) (
  input  logic [CRC_W-1:0]  crc_in,
  input  logic [0:DATA_W-1] data,
  output logic [CRC_W-1:0]  crc_out
);

  logic [CRC_MAX_W-1:0] acc;
  logic [DATA_W-1:0]    shreg;

  // Walk the beat by shifting a copy so the MSB is always the next bit to fold.
  always_comb begin
    acc   = 32'(crc_in);
    shreg = data;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      acc   = crc_fold_bit(acc, shreg[DATA_W-1], 32'(POLY), CRC_W);
      shreg = shreg << 1;
    end
    crc_out = acc[CRC_W-1:0];
  end

endmodule

// File: rtl/crc_stream_enc.sv
// Streaming CRC encoder with valid/ready on both sides and a single output
// register; per-word check bits (MODE 0) or a trailing per-frame CRC beat (MODE 1).
module crc_stream_enc
  import crc_stream_pkg::*;
#(
  parameter int unsigned      DATA_W = 32,
  parameter int unsigned      CRC_W  = 7,
  parameter logic [CRC_W-1:0] POLY   = 7'h09,
  parameter logic [CRC_W-1:0] INIT   = '0,
  parameter int unsigned      MODE   = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_clear,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [0:DATA_W-1] i_data,
  input  logic              i_last,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [0:DATA_W-1] o_data,
  output logic [0:CRC_W-1]  o_par,
  output logic              o_is_par,
  output logic              o_last
);

  crc_state_e       state_q, state_d;
  logic [CRC_W-1:0] crc_q, crc_d;
  logic [CRC_W-1:0] fold_in, fold_out;
  logic             out_free;
  logic             accept;
  logic             load_par;

  assign out_free = ~o_valid | i_ready;
  assign o_ready  = ~i_clear & (state_q != ST_PAR_OUT) & out_free;
  assign accept   = i_valid & o_ready;

  // Per-word mode always folds from INIT; per-frame mode folds the running CRC.
  assign fold_in = (MODE == MODE_FRAME) ? crc_q : INIT;

  crc_fold_comb #(
    .DATA_W (DATA_W),
    .CRC_W  (CRC_W),
    .POLY   (POLY)
  ) u_fold (
    .crc_in  (fold_in),
    .data    (i_data),
    .crc_out (fold_out)
  );

  always_comb begin
    state_d  = state_q;
    crc_d    = crc_q;
    load_par = 1'b0;
    if (MODE == MODE_FRAME) begin
      case (state_q)
        ST_IDLE, ST_ACC: begin
          if (accept) begin
            crc_d   = fold_out;
            state_d = i_last ? ST_PAR_OUT : ST_ACC;
          end
        end
        ST_PAR_OUT: begin
          if (out_free) begin
            load_par = 1'b1;
            crc_d    = INIT;
            state_d  = ST_IDLE;
          end
        end
        default: begin
          crc_d   = INIT;
          state_d = ST_IDLE;
        end
      endcase
      if (i_clear) begin
        load_par = 1'b0;
        crc_d    = INIT;
        state_d  = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      crc_q   <= INIT;
    end else begin
      state_q <= state_d;
      crc_q   <= crc_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      o_valid  <= 1'b0;
      o_data   <= '0;
      o_par    <= '0;
      o_is_par <= 1'b0;
      o_last   <= 1'b0;
    end else if (i_clear) begin
      o_valid <= 1'b0;
    end else if (accept) begin
      o_valid  <= 1'b1;
      o_data   <= i_data;
      o_is_par <= 1'b0;
      if (MODE == MODE_WORD) begin
        o_par  <= fold_out;
        o_last <= i_last;
      end else begin
        o_par  <= '0;
        o_last <= 1'b0;
      end
    end else if (load_par) begin
      o_valid  <= 1'b1;
      o_data   <= '0;
      o_par    <= crc_q;
      o_is_par <= 1'b1;
      o_last   <= 1'b1;
    end else if (i_ready) begin
      o_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_crc_stream_enc.sv
// Bench for crc_stream_enc: a per-word instance (32-bit beats) and a per-frame
// instance (8-bit beats) checked against a polynomial-division reference.
module tb_crc_stream_enc;

  logic clk;
  logic rst_n;

  logic        w_clear, w_i_valid, w_o_ready, w_i_last, w_o_valid, w_i_ready, w_o_is_par, w_o_last;
  logic [0:31] w_i_data, w_o_data;
  logic [0:6]  w_o_par;

  logic        f_clear, f_i_valid, f_o_ready, f_i_last, f_o_valid, f_i_ready, f_o_is_par, f_o_last;
  logic [0:7]  f_i_data, f_o_data;
  logic [0:6]  f_o_par;

  int          n_checks;
  int          n_errors;
  int          ready_mode;
  logic [16:0] exp_q[$];
  logic [7:0]  fbytes[0:15];

  crc_stream_enc #(.DATA_W(32), .CRC_W(7), .POLY(7'h09), .INIT(7'h00), .MODE(0)) u_word (
    .clk(clk), .reset_n(rst_n), .i_clear(w_clear), .i_valid(w_i_valid), .o_ready(w_o_ready),
    .i_data(w_i_data), .i_last(w_i_last), .o_valid(w_o_valid), .i_ready(w_i_ready),
    .o_data(w_o_data), .o_par(w_o_par), .o_is_par(w_o_is_par), .o_last(w_o_last)
  );

  crc_stream_enc #(.DATA_W(8), .CRC_W(7), .POLY(7'h09), .INIT(7'h00), .MODE(1)) u_frame (
    .clk(clk), .reset_n(rst_n), .i_clear(f_clear), .i_valid(f_i_valid), .o_ready(f_o_ready),
    .i_data(f_i_data), .i_last(f_i_last), .o_valid(f_o_valid), .i_ready(f_i_ready),
    .o_data(f_o_data), .o_par(f_o_par), .o_is_par(f_o_is_par), .o_last(f_o_last)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Remainder of M(x) * x^7 modulo x^7 + x^3 + 1, first message bit at the top.
  function automatic logic [6:0] ref_crc(input logic [255:0] msg, input int nbits);
    logic [255:0] v;
    v = msg << 7;
    for (int i = nbits + 6; i >= 7; i--)
      if (((v >> i) & 256'd1) != 256'd0) v = v ^ (256'h89 << (i - 7));
    return v[6:0];
  endfunction

  function automatic logic [6:0] ref_frame_crc(input int n);
    logic [255:0] msg;
    msg = '0;
    for (int i = 0; i < n; i++) msg = (msg << 8) | 256'(fbytes[i]);
    return ref_crc(msg, n * 8);
  endfunction

  initial begin
    f_i_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (ready_mode)
        1:       f_i_ready = 1'($urandom_range(0, 1));
        2:       f_i_ready = 1'b0;
        default: f_i_ready = 1'b1;
      endcase
    end
  end

  always @(negedge clk) begin
    if (rst_n && f_o_valid && f_i_ready) begin
      chk("f_beat_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        logic [16:0] e;
        e = exp_q.pop_front();
        if (e[1]) chk("f_crc_beat", 64'({f_o_data, f_o_par, f_o_is_par, f_o_last}), 64'(e));
        else      chk("f_data_beat", 64'({f_o_data, f_o_par, f_o_is_par, f_o_last}), 64'(e));
      end
    end
  end

  task automatic load_ascii();
    for (int i = 0; i < 9; i++) fbytes[i] = 8'h31 + 8'(i);
  endtask

  task automatic push_data(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back({fbytes[i], 7'h00, 1'b0, 1'b0});
  endtask

  task automatic push_crc(input logic [6:0] crc);
    exp_q.push_back({8'h00, crc, 1'b1, 1'b1});
  endtask

  // Called at posedge+1; returns at posedge+1 after the beat was accepted.
  task automatic send_beat(input logic [7:0] d, input logic last, output int stalls);
    bit ok;
    f_i_valid = 1'b1;
    f_i_data  = d;
    f_i_last  = last;
    stalls    = 0;
    ok        = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (f_o_ready) begin
        ok = 1'b1;
        break;
      end
      stalls++;
    end
    if (!ok) chk("f_accept_timeout", 64'(f_o_ready), 64'd1);
    @(posedge clk);
    #1;
    f_i_valid = 1'b0;
    f_i_last  = 1'b0;
  endtask

  task automatic send_frame(input int n, output int stalls);
    int s;
    stalls = 0;
    for (int i = 0; i < n; i++) begin
      send_beat(fbytes[i], i == n - 1, s);
      stalls += s;
    end
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 1000; k++) begin
      if (exp_q.size() == 0 && !f_o_valid) break;
      @(posedge clk);
      #1;
    end
    chk("f_drain", 64'({exp_q.size() != 0, f_o_valid}), 64'd0);
  endtask

  task automatic w_word(input logic [31:0] d, input logic last);
    w_i_valid = 1'b1;
    w_i_data  = d;
    w_i_last  = last;
    @(negedge clk);
    chk("w_ready", 64'(w_o_ready), 64'd1);
    @(posedge clk);
    #1;
    w_i_valid = 1'b0;
    chk("w_beat", 64'({w_o_valid, w_o_data, w_o_par, w_o_last, w_o_is_par}),
        64'({1'b1, d, ref_crc(256'(d), 32), last, 1'b0}));
  endtask

  initial begin
    int          s, s1, s2, n;
    logic [31:0] d, held;
    n_checks  = 0;
    n_errors  = 0;
    ready_mode = 0;
    rst_n     = 1'b0;
    w_clear   = 1'b0; w_i_valid = 1'b0; w_i_last = 1'b0; w_i_ready = 1'b1; w_i_data = '0;
    f_clear   = 1'b0; f_i_valid = 1'b0; f_i_last = 1'b0; f_i_data = '0;

    #12;
    chk("reset_f_outputs", 64'({f_o_valid, f_o_data, f_o_par, f_o_is_par, f_o_last}), 64'd0);
    chk("reset_w_outputs", 64'({w_o_valid, w_o_data, w_o_par, w_o_is_par, w_o_last}), 64'd0);
    #11 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("reset_f_ready", 64'(f_o_ready), 64'd1);

    // Per-word mode: directed values then random words.
    w_word(32'h0000_0001, 1'b0);
    chk("w_par_one", 64'(w_o_par), 64'h09);
    w_word(32'h0000_0000, 1'b1);
    chk("w_par_zero", 64'(w_o_par), 64'h00);
    for (int i = 0; i < 16; i++) w_word($urandom, 1'($urandom_range(0, 1)));

    // Per-word backpressure: output register must hold while downstream stalls.
    held = 32'hDEAD_BEEF;
    w_word(held, 1'b1);
    w_i_ready = 1'b0;
    w_i_valid = 1'b1;
    w_i_data  = 32'h1234_5678;
    repeat (3) @(posedge clk);
    #1;
    chk("w_stall_hold", 64'({w_o_valid, w_o_data}), 64'({1'b1, held}));
    @(negedge clk);
    chk("w_stall_ready", 64'(w_o_ready), 64'd0);
    @(posedge clk);
    #1;
    w_i_valid = 1'b0;
    w_i_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("w_drained", 64'(w_o_valid), 64'd0);

    // Per-frame: reference frame with no stalls.
    load_ascii();
    push_data(9);
    push_crc(7'h75);
    send_frame(9, s);
    chk("f_frame_stalls", 64'(s), 64'd0);
    wait_drain();

    // Back-to-back frames: exactly one o_ready bubble per frame.
    @(posedge clk);
    #1;
    push_data(9); push_crc(7'h75);
    push_data(9); push_crc(7'h75);
    send_frame(9, s1);
    send_frame(9, s2);
    chk("f_b2b_first_stalls", 64'(s1), 64'd0);
    chk("f_b2b_bubble1", 64'(s2), 64'd1);
    @(negedge clk);
    chk("f_b2b_bubble2", 64'(f_o_ready), 64'd0);
    @(negedge clk);
    chk("f_b2b_ready_after", 64'(f_o_ready), 64'd1);
    @(posedge clk);
    #1;
    wait_drain();

    // Random backpressure on the reference frame.
    ready_mode = 1;
    push_data(9); push_crc(7'h75);
    send_frame(9, s);
    wait_drain();

    // Single-beat frame, then random frames under backpressure.
    ready_mode = 0;
    fbytes[0] = 8'($urandom);
    push_data(1); push_crc(ref_frame_crc(1));
    send_frame(1, s);
    wait_drain();
    ready_mode = 1;
    for (int f = 0; f < 5; f++) begin
      n = $urandom_range(1, 16);
      for (int i = 0; i < n; i++) fbytes[i] = 8'($urandom);
      push_data(n); push_crc(ref_frame_crc(n));
      send_frame(n, s);
      wait_drain();
    end
    ready_mode = 0;

    // Abort after beat 4: beat 4 is held in the output register and discarded.
    @(posedge clk);
    #1;
    load_ascii();
    push_data(3);
    for (int i = 0; i < 4; i++) send_beat(fbytes[i], 1'b0, s);
    ready_mode = 2;
    f_clear = 1'b1;
    @(negedge clk);
    chk("f_clear_ready", 64'(f_o_ready), 64'd0);
    @(posedge clk);
    #1;
    f_clear = 1'b0;
    chk("f_clear_valid", 64'(f_o_valid), 64'd0);
    ready_mode = 0;
    push_data(9); push_crc(7'h75);
    send_frame(9, s);
    wait_drain();

    // Asynchronous reset mid-frame with an output beat pending.
    @(posedge clk);
    #1;
    ready_mode = 2;
    @(posedge clk);
    #1;
    send_beat(8'hA5, 1'b0, s);
    chk("f_pending_valid", 64'(f_o_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("f_async_reset", 64'({f_o_valid, f_o_data, f_o_par, f_o_is_par, f_o_last}), 64'd0);
    chk("w_async_reset", 64'({w_o_valid, w_o_data, w_o_par, w_o_is_par, w_o_last}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ready_mode = 0;
    @(posedge clk);
    #1;
    load_ascii();
    push_data(9); push_crc(7'h75);
    send_frame(9, s);
    chk("f_post_reset_stalls", 64'(s), 64'd0);
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
